// File: rtl/line_window_buffer.sv
// ----------------------------------------------------------------------------
// line_window_buffer
//
// Sliding KxK window generator for the conv datapath. Raster-order pixels are
// accepted one per cycle when in_valid is high. K-1 line memories hold the
// previous image rows. A KxK shift register holds the window. Row and column
// counters decide when the window holds a complete, in-frame KxK block.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active-low
//   in_valid   : pixel_in is accepted this cycle (no backpressure)
//   pixel_in   : raster-order pixel, DATA_W bits
//   win_valid  : win_out holds a complete window (registered)
//   win_out    : window; element (i,j) at bits [(i*K+j)*DATA_W +: DATA_W];
//                row 0 is the oldest image row, column K-1 is the newest pixel
//   win_row    : image row of the window's bottom-right pixel
//   win_col    : image column of the window's bottom-right pixel
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// ----------------------------------------------------------------------------
module line_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            pixel_in,
    output logic                         win_valid,
    output logic [K*K*DATA_W-1:0]        win_out,
    output logic [$clog2(IMG_H)-1:0]     win_row,
    output logic [$clog2(IMG_W)-1:0]     win_col,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // Position counters of the next pixel to be accepted
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [CW-1:0]     col_nxt_s;
    logic [RW-1:0]     row_nxt_s;
    logic              col_last_s;
    logic              row_last_s;
    logic              pos_ok_s;

    // Line memories: line_mem_r[0] holds the previous row, line_mem_r[K-2] the oldest
    logic [DATA_W-1:0] line_mem_r [0:K-2][0:IMG_W-1];
    // Window registers: win_r[i][j], row i, column j
    logic [DATA_W-1:0] win_r      [0:K-1][0:K-1];
    // Tap column entering the window, oldest row first
    logic [DATA_W-1:0] tap_s      [0:K-1];

    logic              win_valid_r;
    logic              frame_done_r;
    logic [RW-1:0]     win_row_r;
    logic [CW-1:0]     win_col_r;

    // Counter wrap logic and window-position qualification
    always_comb begin
        col_last_s = (col_r == CW'(IMG_W - 1));
        row_last_s = (row_r == RW'(IMG_H - 1));
        pos_ok_s   = (row_r >= RW'(K - 1)) && (col_r >= CW'(K - 1));
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        if (col_last_s) begin
            col_nxt_s = {CW{1'b0}};
            if (row_last_s) begin
                row_nxt_s = {RW{1'b0}};
            end else begin
                row_nxt_s = row_r + RW'(1);
            end
        end else begin
            col_nxt_s = col_r + CW'(1);
            row_nxt_s = row_r;
        end
    end

    // Tap column: stored rows at the current column, then the incoming pixel
    always_comb begin
        for (int i = 0; i < K; i++) begin
            tap_s[i] = {DATA_W{1'b0}};
        end
        for (int i = 0; i < K - 1; i++) begin
            tap_s[i] = line_mem_r[K-2-i][col_r];
        end
        tap_s[K-1] = pixel_in;
    end

    // Counters, line memories, window shift and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            win_row_r    <= {RW{1'b0}};
            win_col_r    <= {CW{1'b0}};
            for (int i = 0; i < K - 1; i++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    line_mem_r[i][c] <= {DATA_W{1'b0}};
                end
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_r[i][j] <= {DATA_W{1'b0}};
                end
            end
        end else if (in_valid) begin
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            win_valid_r  <= pos_ok_s;
            frame_done_r <= col_last_s && row_last_s;
            win_row_r    <= row_r;
            win_col_r    <= col_r;
            // Each line memory passes its column entry one row further back
            for (int i = K - 2; i >= 1; i--) begin
                line_mem_r[i][col_r] <= line_mem_r[i-1][col_r];
            end
            line_mem_r[0][col_r] <= pixel_in;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_r[i][j] <= win_r[i][j+1];
                end
                win_r[i][K-1] <= tap_s[i];
            end
        end else begin
            // Idle: all state holds, pulses drop
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    // Flatten the window registers onto the output bus
    always_comb begin
        win_out = {(K*K*DATA_W){1'b0}};
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_out[(i*K+j)*DATA_W +: DATA_W] = win_r[i][j];
            end
        end
    end

    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;

endmodule
